// File: rtl/param_accum_cpu.sv
// param_accum_cpu: parametrised accumulator CPU with serially loaded program and data memories.
// Mode 0 loads program nibbles and mode 1 loads data words, both at pc with pc post-increment.
// Mode 2 sets pc and clears halted. Mode 3 runs one instruction per clock.
// Optional feature macro: CPU_MUL_EN. When it is defined, opcode 3 is a combinational multiply.
// When it is undefined, opcode 3 behaves as a NOP.
// Write strobe semantics: wr_valid is sampled on each rising edge in the three load modes.
// A write happens exactly on an edge where wr_valid=1. There is no ready; the core always accepts.
// In RUN mode, wr_valid is ignored.
module param_accum_cpu #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [1:0]        mode,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              ext_cond,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] acc,
  output logic              zero,
  output logic              carry,
  output logic              halted
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int SH_W  = $clog2(DATA_W);

  typedef enum logic [1:0] {
    MODE_LOADPROG = 2'd0,
    MODE_LOADDATA = 2'd1,
    MODE_SETPC    = 2'd2,
    MODE_RUN      = 2'd3
  } mode_e;

  typedef enum logic [3:0] {
    OP_LOAD  = 4'd0,  OP_STORE = 4'd1,  OP_ADD  = 4'd2,  OP_MUL  = 4'd3,
    OP_SUB   = 4'd4,  OP_SHL   = 4'd5,  OP_SHR  = 4'd6,  OP_JMPX = 4'd7,
    OP_JZ    = 4'd8,  OP_AND   = 4'd9,  OP_OR   = 4'd10, OP_XOR  = 4'd11,
    OP_EQ    = 4'd12, OP_NOT   = 4'd13, OP_NOP  = 4'd14, OP_HALT = 4'd15
  } op_e;

  // Architectural state
  logic [3:0]        prog_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic              z_q, z_d;
  logic              c_q, c_d;
  logic              halted_q, halted_d;

  // Memory write controls
  logic              prog_we;
  logic              data_we;
  logic [ADDR_W-1:0] data_waddr;
  logic [DATA_W-1:0] data_wdata;
  logic              upd_z;

  // Datapath terms
  op_e               op;
  logic [DATA_W-1:0] d_w;
  logic [ADDR_W-1:0] pc_inc;
  logic [DATA_W:0]   sum_w;
  logic [DATA_W-1:0] diff_w;
  logic [SH_W-1:0]   sh_amt;
  logic [DATA_W:0]   shl_w;
  logic [DATA_W:0]   shr_w;

  assign op     = op_e'(prog_q[pc_q]);
  assign d_w    = data_q[pc_q];
  assign pc_inc = pc_q + ADDR_W'(1);
  assign sum_w  = {1'b0, acc_q} + {1'b0, d_w};
  assign diff_w = acc_q - d_w;
  // The shift distance is clamped to DATA_W-1, so the last bit shifted out always comes from acc.
  assign sh_amt = (d_w > DATA_W'(DATA_W - 1)) ? SH_W'(DATA_W - 1) : d_w[SH_W-1:0];
  // The extra bit on each side catches the last bit shifted out. It is 0 when the shift is 0.
  assign shl_w  = {1'b0, acc_q} << sh_amt;
  assign shr_w  = {acc_q, 1'b0} >> sh_amt;

`ifdef CPU_MUL_EN
  logic [2*DATA_W-1:0] prod_w;
  assign prod_w = {{DATA_W{1'b0}}, acc_q} * {{DATA_W{1'b0}}, d_w};
`endif

  assign pc     = pc_q;
  assign acc    = acc_q;
  assign zero   = z_q;
  assign carry  = c_q;
  assign halted = halted_q;

  // Next-state selection for load modes and single-cycle instruction execution
  always_comb begin
    pc_d       = pc_q;
    acc_d      = acc_q;
    z_d        = z_q;
    c_d        = c_q;
    halted_d   = halted_q;
    prog_we    = 1'b0;
    data_we    = 1'b0;
    data_waddr = pc_q;
    data_wdata = wr_data;
    upd_z      = 1'b0;
    case (mode_e'(mode))
      MODE_LOADPROG: begin
        if (wr_valid) begin
          prog_we = 1'b1;
          pc_d    = pc_inc;
        end
      end
      MODE_LOADDATA: begin
        if (wr_valid) begin
          data_we = 1'b1;
          pc_d    = pc_inc;
        end
      end
      MODE_SETPC: begin
        if (wr_valid) begin
          pc_d     = wr_data[ADDR_W-1:0];
          halted_d = 1'b0;
        end
      end
      MODE_RUN: begin
        if (!halted_q) begin
          pc_d = pc_inc;
          case (op)
            OP_LOAD:  begin acc_d = d_w; upd_z = 1'b1; end
            OP_STORE: begin
              data_we    = 1'b1;
              data_waddr = d_w[ADDR_W-1:0];
              data_wdata = acc_q;
            end
            OP_ADD:   begin {c_d, acc_d} = sum_w; upd_z = 1'b1; end
            OP_MUL: begin
`ifdef CPU_MUL_EN
              acc_d = prod_w[DATA_W-1:0];
              c_d   = |prod_w[2*DATA_W-1:DATA_W];
              upd_z = 1'b1;
`endif
            end
            OP_SUB:   begin acc_d = diff_w; c_d = (acc_q < d_w); upd_z = 1'b1; end
            OP_SHL:   begin acc_d = shl_w[DATA_W-1:0]; c_d = shl_w[DATA_W]; upd_z = 1'b1; end
            OP_SHR:   begin acc_d = shr_w[DATA_W:1]; c_d = shr_w[0]; upd_z = 1'b1; end
            OP_JMPX:  if (ext_cond) pc_d = d_w[ADDR_W-1:0];
            OP_JZ:    if (z_q) pc_d = d_w[ADDR_W-1:0];
            OP_AND:   begin acc_d = acc_q & d_w; upd_z = 1'b1; end
            OP_OR:    begin acc_d = acc_q | d_w; upd_z = 1'b1; end
            OP_XOR:   begin acc_d = acc_q ^ d_w; upd_z = 1'b1; end
            OP_EQ:    begin acc_d = {{(DATA_W-1){1'b0}}, (acc_q == d_w)}; upd_z = 1'b1; end
            OP_NOT:   begin acc_d = ~acc_q; upd_z = 1'b1; end
            OP_NOP:   ;
            OP_HALT:  begin halted_d = 1'b1; pc_d = pc_q; end
            default:  ;
          endcase
          if (upd_z) z_d = (acc_d == '0);
        end
      end
      default: ;
    endcase
  end

  // Register and memory update. Reset clears the registers and both memories.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q     <= '0;
      acc_q    <= '0;
      z_q      <= 1'b0;
      c_q      <= 1'b0;
      halted_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        prog_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      pc_q     <= pc_d;
      acc_q    <= acc_d;
      z_q      <= z_d;
      c_q      <= c_d;
      halted_q <= halted_d;
      if (prog_we) prog_q[pc_q] <= wr_data[3:0];
      if (data_we) data_q[data_waddr] <= data_wdata;
    end
  end

endmodule

// File: tb/tb_param_accum_cpu.sv
// Testbench for param_accum_cpu with DATA_W=8 and ADDR_W=4.
// The bench runs a vector table, then directed corner sequences, then random traffic against an arithmetic model.
module tb_param_accum_cpu;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int MOD   = 256;

  localparam logic [1:0] M_LP  = 2'd0;
  localparam logic [1:0] M_LD  = 2'd1;
  localparam logic [1:0] M_SP  = 2'd2;
  localparam logic [1:0] M_RUN = 2'd3;

  // ---------------- clock / reset ----------------
  logic          clock = 1'b0;
  logic          reset;
  logic [1:0]    mode;
  logic          wr_valid;
  logic [DW-1:0] wr_data;
  logic          ext_cond;
  logic [AW-1:0] pc;
  logic [DW-1:0] acc;
  logic          zero, carry, halted;

  always #5 clock = ~clock;

  param_accum_cpu #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clock(clock), .reset(reset), .mode(mode), .wr_valid(wr_valid),
    .wr_data(wr_data), .ext_cond(ext_cond), .pc(pc), .acc(acc),
    .zero(zero), .carry(carry), .halted(halted)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_prog [DEPTH];
  int m_data [DEPTH];
  int m_pc, m_acc, m_z, m_c, m_halt;

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_prog[i] = 0;
      m_data[i] = 0;
    end
    m_pc = 0; m_acc = 0; m_z = 0; m_c = 0; m_halt = 0;
  endtask

  task automatic set_acc(input int r);
    m_acc = r % MOD;
    m_z   = (m_acc == 0) ? 1 : 0;
  endtask

  task automatic model_step(input int md, input int v, input int wd, input int ext);
    int op, d, npc, sh;
    case (md)
      0: if (v != 0) begin m_prog[m_pc] = wd % 16; m_pc = (m_pc + 1) % DEPTH; end
      1: if (v != 0) begin m_data[m_pc] = wd; m_pc = (m_pc + 1) % DEPTH; end
      2: if (v != 0) begin m_pc = wd % DEPTH; m_halt = 0; end
      default: begin
        if (m_halt == 0) begin
          op  = m_prog[m_pc];
          d   = m_data[m_pc];
          npc = (m_pc + 1) % DEPTH;
          sh  = (d > DW - 1) ? DW - 1 : d;
          case (op)
            0:  set_acc(d);
            1:  m_data[d % DEPTH] = m_acc;
            2:  begin m_c = (m_acc + d >= MOD) ? 1 : 0; set_acc(m_acc + d); end
            3: begin
`ifdef CPU_MUL_EN
              m_c = (m_acc * d >= MOD) ? 1 : 0;
              set_acc(m_acc * d);
`endif
            end
            4:  begin m_c = (m_acc < d) ? 1 : 0; set_acc(m_acc - d + MOD); end
            5:  begin m_c = (sh == 0) ? 0 : (m_acc >> (DW - sh)) & 1; set_acc(m_acc << sh); end
            6:  begin m_c = (sh == 0) ? 0 : (m_acc >> (sh - 1)) & 1; set_acc(m_acc >> sh); end
            7:  if (ext != 0) npc = d % DEPTH;
            8:  if (m_z != 0) npc = d % DEPTH;
            9:  set_acc(m_acc & d);
            10: set_acc(m_acc | d);
            11: set_acc(m_acc ^ d);
            12: set_acc((m_acc == d) ? 1 : 0);
            13: set_acc(MOD - 1 - m_acc);
            14: ;
            default: begin m_halt = 1; npc = m_pc; end
          endcase
          m_pc = npc;
        end
      end
    endcase
  endtask

  task automatic check_model(input string tag);
    check({tag, ".pc"},     int'(pc),     m_pc);
    check({tag, ".acc"},    int'(acc),    m_acc);
    check({tag, ".zero"},   int'(zero),   m_z);
    check({tag, ".carry"},  int'(carry),  m_c);
    check({tag, ".halted"}, int'(halted), m_halt);
  endtask

  // ---------------- driver tasks ----------------
  // Drive inputs after an edge, let one edge pass, then compare shortly after it.
  task automatic apply(input logic [1:0] md, input logic v, input logic [DW-1:0] wd,
                       input logic ext, input string tag);
    mode = md; wr_valid = v; wr_data = wd; ext_cond = ext;
    @(posedge clock);
    model_step(int'(md), int'(v), int'(wd), int'(ext));
    #1;
    check_model(tag);
  endtask

  task automatic wr(input logic [1:0] md, input logic [DW-1:0] wd);
    apply(md, 1'b1, wd, 1'b0, "wr");
  endtask

  task automatic run(input int n, input logic ext);
    for (int i = 0; i < n; i++) apply(M_RUN, 1'b0, 8'h00, ext, "run");
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0]    mode;
    logic          v;
    logic [DW-1:0] wd;
    logic          ext;
    logic [AW-1:0] e_pc;
    logic [DW-1:0] e_acc;
    logic          e_z, e_c, e_h;
  } vec_t;

  localparam int NVEC = 15;
  vec_t vecs [NVEC];

  // Watchdog against a stuck run
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Program {LOAD,ADD,HALT} with data {200,100}; run, halt, ignore wr_valid, then reload while halted.
    vecs[0]  = '{M_SP,  1'b1, 8'd0,   1'b0, 4'd0, 8'd0,  1'b0, 1'b0, 1'b0};
    vecs[1]  = '{M_LP,  1'b1, 8'd0,   1'b0, 4'd1, 8'd0,  1'b0, 1'b0, 1'b0};
    vecs[2]  = '{M_LP,  1'b1, 8'd2,   1'b0, 4'd2, 8'd0,  1'b0, 1'b0, 1'b0};
    vecs[3]  = '{M_LP,  1'b1, 8'd15,  1'b0, 4'd3, 8'd0,  1'b0, 1'b0, 1'b0};
    vecs[4]  = '{M_SP,  1'b1, 8'd0,   1'b0, 4'd0, 8'd0,  1'b0, 1'b0, 1'b0};
    vecs[5]  = '{M_LD,  1'b1, 8'd200, 1'b0, 4'd1, 8'd0,  1'b0, 1'b0, 1'b0};
    vecs[6]  = '{M_LD,  1'b1, 8'd100, 1'b0, 4'd2, 8'd0,  1'b0, 1'b0, 1'b0};
    vecs[7]  = '{M_LP,  1'b0, 8'd9,   1'b0, 4'd2, 8'd0,  1'b0, 1'b0, 1'b0};
    vecs[8]  = '{M_SP,  1'b1, 8'd0,   1'b0, 4'd0, 8'd0,  1'b0, 1'b0, 1'b0};
    vecs[9]  = '{M_RUN, 1'b0, 8'd0,   1'b0, 4'd1, 8'd200, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{M_RUN, 1'b0, 8'd0,   1'b0, 4'd2, 8'd44, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{M_RUN, 1'b0, 8'd0,   1'b0, 4'd2, 8'd44, 1'b0, 1'b1, 1'b1};
    vecs[12] = '{M_RUN, 1'b1, 8'd7,   1'b0, 4'd2, 8'd44, 1'b0, 1'b1, 1'b1};
    vecs[13] = '{M_LD,  1'b1, 8'd55,  1'b0, 4'd3, 8'd44, 1'b0, 1'b1, 1'b1};
    vecs[14] = '{M_SP,  1'b1, 8'd0,   1'b0, 4'd0, 8'd44, 1'b0, 1'b1, 1'b0};

    mode = M_SP; wr_valid = 1'b0; wr_data = '0; ext_cond = 1'b0; reset = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check("reset.pc", int'(pc), 0);
    check("reset.acc", int'(acc), 0);
    check("reset.zero", int'(zero), 0);
    check("reset.carry", int'(carry), 0);
    check("reset.halted", int'(halted), 0);
    reset = 1'b1;

    // Vector table
    for (int i = 0; i < NVEC; i++) begin
      mode = vecs[i].mode; wr_valid = vecs[i].v; wr_data = vecs[i].wd; ext_cond = vecs[i].ext;
      @(posedge clock);
      model_step(int'(vecs[i].mode), int'(vecs[i].v), int'(vecs[i].wd), int'(vecs[i].ext));
      #1;
      check($sformatf("vec%0d.pc", i), int'(pc), int'(vecs[i].e_pc));
      check($sformatf("vec%0d.acc", i), int'(acc), int'(vecs[i].e_acc));
      check($sformatf("vec%0d.zero", i), int'(zero), int'(vecs[i].e_z));
      check($sformatf("vec%0d.carry", i), int'(carry), int'(vecs[i].e_c));
      check($sformatf("vec%0d.halted", i), int'(halted), int'(vecs[i].e_h));
    end

    // Program {LOAD,SUB,JZ} with data {7,7,9}, then again with data[1]=8
    wr(M_SP, 8'd0); wr(M_LP, 8'd0); wr(M_LP, 8'd4); wr(M_LP, 8'd8);
    wr(M_SP, 8'd0); wr(M_LD, 8'd7); wr(M_LD, 8'd7); wr(M_LD, 8'd9);
    wr(M_SP, 8'd0);
    run(2, 1'b0);
    check("jz.acc", int'(acc), 0);
    check("jz.zero", int'(zero), 1);
    check("jz.carry", int'(carry), 0);
    run(1, 1'b0);
    check("jz.pc_taken", int'(pc), 9);
    wr(M_SP, 8'd1); wr(M_LD, 8'd8); wr(M_SP, 8'd0);
    run(3, 1'b0);
    check("borrow.acc", int'(acc), 255);
    check("borrow.carry", int'(carry), 1);
    check("borrow.zero", int'(zero), 0);
    check("borrow.pc", int'(pc), 3);

    // Async reset between edges while in RUN
    #2 reset = 1'b0;
    #1;
    check("areset.pc", int'(pc), 0);
    check("areset.acc", int'(acc), 0);
    check("areset.zero", int'(zero), 0);
    check("areset.carry", int'(carry), 0);
    check("areset.halted", int'(halted), 0);
    #1 reset = 1'b1;
    model_reset();
    // Every cleared program word is LOAD of a cleared data word
    wr(M_SP, 8'd0);
    run(DEPTH, 1'b0);
    check("cleared.pc", int'(pc), 0);
    check("cleared.acc", int'(acc), 0);
    check("cleared.zero", int'(zero), 1);
    check("cleared.halted", int'(halted), 0);

    // pc wrap in LOADPROG, RUN and LOADDATA
    wr(M_SP, 8'd15); wr(M_LP, 8'd14);
    check("wrap_lp.pc", int'(pc), 0);
    wr(M_SP, 8'd15); run(1, 1'b0);
    check("wrap_run.pc", int'(pc), 0);
    wr(M_SP, 8'd15); wr(M_LD, 8'h5A);
    check("wrap_ld.pc", int'(pc), 0);
    wr(M_SP, 8'd15); wr(M_LP, 8'd0); wr(M_SP, 8'd15); run(1, 1'b0);
    check("wrap_ld.data15", int'(acc), 8'h5A);
    check("wrap_ld.pc2", int'(pc), 0);

    // Program {LOAD,MUL} with data {20,13}
    wr(M_SP, 8'd0); wr(M_LP, 8'd0); wr(M_LP, 8'd3);
    wr(M_SP, 8'd0); wr(M_LD, 8'd20); wr(M_LD, 8'd13);
    wr(M_SP, 8'd0);
    run(2, 1'b0);
`ifdef CPU_MUL_EN
    check("mul.acc", int'(acc), 4);
    check("mul.carry", int'(carry), 1);
`else
    check("mul_off.acc", int'(acc), 20);
    check("mul_off.carry", int'(carry), 0);
`endif
    check("mul.pc", int'(pc), 2);

    // Program {LOAD,STORE,LOAD} with data {5,2,0}
    wr(M_SP, 8'd0); wr(M_LP, 8'd0); wr(M_LP, 8'd1); wr(M_LP, 8'd0);
    wr(M_SP, 8'd0); wr(M_LD, 8'd5); wr(M_LD, 8'd2); wr(M_LD, 8'd0);
    wr(M_SP, 8'd0);
    run(3, 1'b0);
    check("store.acc", int'(acc), 5);
    check("store.pc", int'(pc), 3);
    // Write strobe toggled while in RUN is ignored
    for (int i = 0; i < 6; i++)
      apply(M_RUN, 1'(i % 2), 8'($urandom_range(0, 255)), 1'b0, "run_wr");

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      int r;
      logic [1:0] md;
      r  = $urandom_range(0, 9);
      md = (r < 2) ? M_LP : (r < 4) ? M_LD : (r == 4) ? M_SP : M_RUN;
      apply(md, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
            1'($urandom_range(0, 1)), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
